// File: rtl/shift_seq_if.sv
// Handshake and result bundle between a shift_sequencer and its requester.
interface shift_seq_if #(
  parameter int unsigned M = 4
) ();
  logic         start;
  logic [1:0]   op;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [M-1:0] R;
  logic         C;
  logic         N;
  logic         V;
  logic         Z;

  modport master (output start, op, A, B, input busy, done, R, C, N, V, Z);
  modport slave  (input start, op, A, B, output busy, done, R, C, N, V, Z);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit position per cycle, with C/N/V/Z flags on completion.
// Define SHIFT_SEQ_ROTATE_EN to make op=11 a rotate-left; otherwise op=11 behaves as SHL.
module shift_sequencer #(
  parameter int unsigned M = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_seq_if.slave  bus
);
  localparam int unsigned  CW    = $clog2(M + 1);
  localparam logic [M-1:0] M_VAL = M'(M);
  localparam logic [1:0]   OP_SHL = 2'b00;
  localparam logic [1:0]   OP_SHR = 2'b01;
  localparam logic [1:0]   OP_SRA = 2'b10;
  localparam logic [1:0]   OP_ROL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          vacc_q, vacc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [M-1:0]  r_q, r_d;
  logic          c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;

  logic [1:0]    op_in_c;
  logic [CW-1:0] k_in_c;
  logic [M-1:0]  step_c;
  logic          out_c;
  logic          msb_chg_c;

  // Decode the requested op and its effective step count
  always_comb begin
`ifdef SHIFT_SEQ_ROTATE_EN
    op_in_c = bus.op;
`else
    op_in_c = (bus.op == OP_ROL) ? OP_SHL : bus.op;
`endif
    if (op_in_c == OP_ROL) begin
      k_in_c = CW'(bus.B % M_VAL);
    end else if (bus.B >= M_VAL) begin
      k_in_c = CW'(M);
    end else begin
      k_in_c = CW'(bus.B);
    end
  end

  // One-position step of the working register and the bit it pushes out
  always_comb begin
    step_c = work_q;
    out_c  = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_c = {work_q[M-2:0], 1'b0};
        out_c  = work_q[M-1];
      end
      OP_SHR: begin
        step_c = {1'b0, work_q[M-1:1]};
        out_c  = work_q[0];
      end
      OP_SRA: begin
        step_c = {work_q[M-1], work_q[M-1:1]};
        out_c  = work_q[0];
      end
      default: begin
        step_c = {work_q[M-2:0], work_q[M-1]};
        out_c  = work_q[M-1];
      end
    endcase
    msb_chg_c = (op_q == OP_SHL) && (step_c[M-1] != work_q[M-1]);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    vacc_d  = vacc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d = bus.A;
          op_d   = op_in_c;
          cnt_d  = k_in_c;
          vacc_d = 1'b0;
          if (k_in_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            r_d     = bus.A;
            c_d     = 1'b0;
            v_d     = 1'b0;
            n_d     = bus.A[M-1];
            z_d     = (bus.A == '0);
          end else begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_c;
        cnt_d  = cnt_q - CW'(1);
        vacc_d = vacc_q | msb_chg_c;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          r_d     = step_c;
          c_d     = out_c;
          v_d     = vacc_q | msb_chg_c;
          n_d     = step_c[M-1];
          z_d     = (step_c == '0);
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SHL;
      vacc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      vacc_q  <= vacc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.R    = r_q;
  assign bus.C    = c_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: arithmetic reference model plus directed literal cases.
module tb_shift_sequencer;
  localparam int unsigned M = 4;
  localparam int MAXLAT = 10;

  typedef struct packed {
    logic [7:0]   k;
    logic [M-1:0] r;
    logic         c;
    logic         v;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  shift_seq_if #(.M(M)) bus ();
  shift_sequencer #(.M(M)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Whole-operation result computed directly from shift arithmetic
  function automatic res_t model(input logic [1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
    res_t o;
    int k, mm, idx;
    logic [1:0] eop;
    logic bitv;
    mm = int'(M);
    eop = op;
`ifndef SHIFT_SEQ_ROTATE_EN
    if (op == 2'b11) eop = 2'b00;
`endif
    o.c = 1'b0;
    o.v = 1'b0;
    if (eop == 2'b11) begin
      k = int'(b) % mm;
      o.r = (k == 0) ? a : ((a << k) | (a >> (mm - k)));
      o.c = (k == 0) ? 1'b0 : o.r[0];
    end else begin
      k = (int'(b) >= mm) ? mm : int'(b);
      case (eop)
        2'b00: begin
          o.r = a << k;
          if (k > 0) o.c = a[mm-k];
          for (int j = 1; j <= k; j++) begin
            idx  = mm - 1 - j;
            bitv = 1'b0;
            if (idx >= 0) bitv = a[idx];
            if (bitv != a[M-1]) o.v = 1'b1;
          end
        end
        2'b01: begin
          o.r = a >> k;
          if (k > 0) o.c = a[k-1];
        end
        default: begin
          o.r = M'($signed(a) >>> k);
          if (k > 0) o.c = a[k-1];
        end
      endcase
    end
    o.k = 8'(k);
    return o;
  endfunction

  res_t in_res, pend;
  assign in_res = model(bus.op, bus.A, bus.B);

  logic         m_valid = 1'b0;
  int           m_left;
  logic         e_busy, e_done, e_c, e_n, e_v, e_z;
  logic [M-1:0] e_r;

  // Timing model: k busy cycles then a one-cycle done carrying the result
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_left  <= 0;
      e_busy  <= 1'b0;
      e_done  <= 1'b0;
      e_r     <= '0;
      e_c     <= 1'b0;
      e_n     <= 1'b0;
      e_v     <= 1'b0;
      e_z     <= 1'b1;
    end else if (m_valid) begin
      e_done <= 1'b0;
      if (!e_done) begin
        if (m_left == 1) begin
          m_left <= 0;
          e_busy <= 1'b0;
          e_done <= 1'b1;
          e_r    <= pend.r;
          e_c    <= pend.c;
          e_v    <= pend.v;
          e_n    <= pend.r[M-1];
          e_z    <= (pend.r == '0);
        end else if (m_left > 1) begin
          m_left <= m_left - 1;
        end else if (bus.start) begin
          if (in_res.k == 8'd0) begin
            e_done <= 1'b1;
            e_r    <= in_res.r;
            e_c    <= in_res.c;
            e_v    <= in_res.v;
            e_n    <= in_res.r[M-1];
            e_z    <= (in_res.r == '0);
          end else begin
            m_left <= int'(in_res.k);
            e_busy <= 1'b1;
            pend   <= in_res;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      check("cycle_outputs",
            32'({bus.busy, bus.done, bus.R, bus.C, bus.N, bus.V, bus.Z}),
            32'({e_busy, e_done, e_r, e_c, e_n, e_v, e_z}));
  end

  // Caller is 1 time unit after a rising edge with the DUT idle
  task automatic run_op(input string name, input logic [1:0] op, input logic [M-1:0] a,
                        input logic [M-1:0] b, input int exp_lat, input logic [M-1:0] exp_r,
                        input logic [3:0] exp_cnvz, input logic [3:0] mask);
    int n, busy_n;
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < MAXLAT) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    check({name, "_R"}, 32'(bus.R), 32'(exp_r));
    check({name, "_CNVZ"}, 32'({bus.C, bus.N, bus.V, bus.Z} & mask), 32'(exp_cnvz & mask));
    @(posedge clk); #1;
  endtask

  task automatic run_free(input logic [1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
    int n;
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < MAXLAT) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check("sweep_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_R", 32'(bus.R), 32'd0);
    check("reset_CNVZ", 32'({bus.C, bus.N, bus.V, bus.Z}), 32'b0001);
    @(posedge clk); #1 rst = 1'b0;

    run_op("shl_3_by_2", 2'b00, 4'b0011, 4'b0010, 3, 4'b1100, 4'b0110, 4'b1111);
    run_op("sra_9_by_1", 2'b10, 4'b1001, 4'b0001, 2, 4'b1100, 4'b1100, 4'b1111);
    run_op("shr_sat",    2'b01, 4'b1111, 4'b0111, 5, 4'b0000, 4'b1001, 4'b1111);
    run_op("shl_zero",   2'b00, 4'b0101, 4'b0000, 1, 4'b0101, 4'b0000, 4'b1111);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("op3_rol",    2'b11, 4'b1000, 4'b0101, 2, 4'b0001, 4'b1000, 4'b1111);
`else
    run_op("op3_as_shl", 2'b11, 4'b1000, 4'b0101, 5, 4'b0000, 4'b0011, 4'b0111);
`endif
    run_op("sra_sat_neg", 2'b10, 4'b1010, 4'b0100, 5, 4'b1111, 4'b1100, 4'b1111);
    run_op("sra_sat_pos", 2'b10, 4'b0110, 4'b1111, 5, 4'b0000, 4'b0001, 4'b1111);
    run_op("shr_6_by_1",  2'b01, 4'b0110, 4'b0001, 2, 4'b0011, 4'b0000, 4'b1111);
    run_op("shr_b_by_2",  2'b01, 4'b1011, 4'b0010, 3, 4'b0010, 4'b1000, 4'b1111);
    run_op("shl_8_by_1",  2'b00, 4'b1000, 4'b0001, 2, 4'b0000, 4'b1011, 4'b1111);
    run_op("shl_4_by_1",  2'b00, 4'b0100, 4'b0001, 2, 4'b1000, 4'b0110, 4'b1111);
    run_op("shl_c_by_1",  2'b00, 4'b1100, 4'b0001, 2, 4'b1000, 4'b1100, 4'b1111);
    run_op("shl_a_by_2",  2'b00, 4'b1010, 4'b0010, 3, 4'b1000, 4'b0110, 4'b1111);

    // Start held high through SHIFT and DONE must not disturb the running op
    bus.start = 1'b1; bus.op = 2'b01; bus.A = 4'b1000; bus.B = 4'b0011;
    @(posedge clk); #1;
    bus.op = 2'b00; bus.A = 4'b1111; bus.B = 4'b0001;
    n = 0; seen = 1'b0;
    while (!seen && n < MAXLAT) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check("ignored_start_latency", 32'(n), 32'd4);
    check("ignored_start_R", 32'(bus.R), 32'b0001);
    check("ignored_start_CNVZ", 32'({bus.C, bus.N, bus.V, bus.Z}), 32'b0000);
    @(posedge clk); #1;

    // Reset during the second SHIFT cycle aborts; reset also beats a start
    bus.start = 1'b1; bus.op = 2'b00; bus.A = 4'b0011; bus.B = 4'b0011;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 bus.start = 1'b1; bus.A = 4'b0001; bus.B = 4'b0001;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_R", 32'(bus.R), 32'd0);
    check("abort_Z", 32'(bus.Z), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_beats_start_busy", 32'(bus.busy), 32'd0);
    check("rst_beats_start_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op("start_after_rst", 2'b00, 4'b0001, 4'b0001, 2, 4'b0010, 4'b0000, 4'b1111);

    for (int op = 0; op < 4; op++)
      for (int b = 0; b < 6; b++)
        run_free(2'(op), 4'b1011 ^ 4'(op * 5), 4'(b));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
